// File: rtl/csr_access_pkg.sv
// Shared types for the CSR access sequencer: operation encoding, FSM states
// and the error-counter geometry.
package csr_access_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

    localparam int unsigned ErrCntW = 8;
    localparam logic [ErrCntW-1:0] ErrCntMax = '1;

endpackage

// File: rtl/csr_err_sat_cnt.sv
// Saturating counter of errored CSR accesses; sticks at its maximum value
// instead of wrapping.
module csr_err_sat_cnt
    import csr_access_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    output logic [ErrCntW-1:0] count_o
);

    logic [ErrCntW-1:0] cnt_d;
    logic [ErrCntW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != ErrCntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/csr_access_seq.sv
// Sequences one read-modify-write access at a time against a shadowed CSR
// primitive and returns the pre-access value with an integrity error flag.
module csr_access_seq
    import csr_access_pkg::*;
#(
    parameter int unsigned      Width  = 32,
    parameter logic [Width-1:0] WrMask = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic [Width-1:0] csr_wr_data_o,
    output logic             csr_wr_en_o,
    output logic [7:0]       err_count_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a raised valid and its payload stay put until that edge.
    csr_state_e       state_d, state_q;
    csr_op_e          op_d, op_q;
    logic [Width-1:0] wdata_d, wdata_q;
    logic [Width-1:0] old_d, old_q;
    logic             err_d, err_q;

    logic [Width-1:0] new_val;
    logic [Width-1:0] final_val;
    logic             wr_en;
    logic [Width-1:0] wr_data;
    logic             err_inc;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_data = '0;
        err_inc = 1'b0;

        unique case (op_q)
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = csr_rd_data_i | wdata_q;
            OP_CLEAR: new_val = csr_rd_data_i & ~wdata_q;
            default:  new_val = csr_rd_data_i;
        endcase
        // Read-only bits always keep the value the primitive currently holds.
        final_val = (csr_rd_data_i & ~WrMask) | (new_val & WrMask);

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d    = csr_op_e'(req_op_i);
                    wdata_d = req_wdata_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                old_d   = csr_rd_data_i;
                err_d   = csr_rd_error_i;
                err_inc = csr_rd_error_i;
                wr_data = final_val;
                wr_en   = !csr_rd_error_i &&
                          ((op_q == OP_WRITE) ||
                           (((op_q == OP_SET) || (op_q == OP_CLEAR)) && (wdata_q != '0)));
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            wdata_q <= '0;
            old_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            err_q   <= err_d;
        end
    end

    csr_err_sat_cnt u_err_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (err_inc),
        .count_o (err_count_o)
    );

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rdata_o   = (state_q == ST_RESP) ? old_q : '0;
    assign rsp_error_o   = (state_q == ST_RESP) ? err_q : 1'b0;
    assign csr_wr_en_o   = wr_en;
    assign csr_wr_data_o = wr_data;

    a_known_ctrl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({csr_wr_en_o, req_ready_o}));

endmodule

// File: tb/tb_csr_access_seq.sv
// Directed bench for csr_access_seq: a full-mask instance and a 16-bit-mask
// instance, acting as the CSR primitive for both.
module tb_csr_access_seq;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic [1:0]  req_op;
    logic [31:0] req_wdata, rsp_rdata, csr_rd_data, csr_wr_data;
    logic        csr_rd_error, csr_wr_en;
    logic [7:0]  err_count;

    logic        m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready, m_rsp_error;
    logic [1:0]  m_req_op;
    logic [31:0] m_req_wdata, m_rsp_rdata, m_csr_rd_data, m_csr_wr_data;
    logic        m_csr_rd_error, m_csr_wr_en;
    logic [7:0]  m_err_count;

    int checks   = 0;
    int failures = 0;

    csr_access_seq u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_error_o    (rsp_error),
        .csr_rd_data_i  (csr_rd_data),
        .csr_rd_error_i (csr_rd_error),
        .csr_wr_data_o  (csr_wr_data),
        .csr_wr_en_o    (csr_wr_en),
        .err_count_o    (err_count)
    );

    csr_access_seq #(.Width(32), .WrMask(32'h0000_FFFF)) u_dut_m (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (m_req_valid),
        .req_ready_o    (m_req_ready),
        .req_op_i       (m_req_op),
        .req_wdata_i    (m_req_wdata),
        .rsp_valid_o    (m_rsp_valid),
        .rsp_ready_i    (m_rsp_ready),
        .rsp_rdata_o    (m_rsp_rdata),
        .rsp_error_o    (m_rsp_error),
        .csr_rd_data_i  (m_csr_rd_data),
        .csr_rd_error_i (m_csr_rd_error),
        .csr_wr_data_o  (m_csr_wr_data),
        .csr_wr_en_o    (m_csr_wr_en),
        .err_count_o    (m_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access on u_dut with rsp_ready high; called at posedge+1 in IDLE.
    task automatic access(input logic [1:0] op, input logic [31:0] wd, input logic err,
                          output logic o_wr_en, output logic [31:0] o_wr_data,
                          output logic o_vld_exec, output logic o_rdy_exec,
                          output logic o_vld_resp, output logic [31:0] o_rdata,
                          output logic o_err, output logic [7:0] o_cnt);
        req_valid    = 1'b1;
        req_op       = op;
        req_wdata    = wd;
        csr_rd_error = err;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_wdata  = '0;
        o_wr_en    = csr_wr_en;
        o_wr_data  = csr_wr_data;
        o_vld_exec = rsp_valid;
        o_rdy_exec = req_ready;
        @(posedge clk); #1;
        csr_rd_error = 1'b0;
        o_vld_resp = rsp_valid;
        o_rdata    = rsp_rdata;
        o_err      = rsp_error;
        o_cnt      = err_count;
        @(posedge clk); #1;
    endtask

    logic        a_wr_en, a_vld_exec, a_rdy_exec, a_vld_resp, a_err;
    logic [31:0] a_wr_data, a_rdata;
    logic [7:0]  a_cnt;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'd0; req_wdata = '0; rsp_ready = 1'b1;
        csr_rd_data = 32'h0000_00F0; csr_rd_error = 1'b0;
        m_req_valid = 1'b0; m_req_op = 2'd0; m_req_wdata = '0; m_rsp_ready = 1'b1;
        m_csr_rd_data = '0; m_csr_rd_error = 1'b0;

        // reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("rst_wr_data", csr_wr_data, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_m_req_ready", {31'd0, m_req_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // masked instance: WRITE all-ones onto 0xAAAA_0000
        m_csr_rd_data = 32'hAAAA_0000;
        m_req_valid = 1'b1; m_req_op = 2'd1; m_req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        chk("mask_write_en", {31'd0, m_csr_wr_en}, 32'd1);
        chk("mask_write_data", m_csr_wr_data, 32'hAAAA_FFFF);
        @(posedge clk); #1;
        chk("mask_write_rdata", m_rsp_rdata, 32'hAAAA_0000);
        @(posedge clk); #1;
        // masked instance: CLEAR all-ones onto all-ones keeps the upper half
        m_csr_rd_data = 32'hFFFF_FFFF;
        m_req_valid = 1'b1; m_req_op = 2'd3; m_req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        chk("mask_clear_data", m_csr_wr_data, 32'hFFFF_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // WRITE with latency checks
        access(2'd1, 32'h1234_5678, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("write_wr_en_t1", {31'd0, a_wr_en}, 32'd1);
        chk("write_wr_data", a_wr_data, 32'h1234_5678);
        chk("write_rsp_not_t1", {31'd0, a_vld_exec}, 32'd0);
        chk("write_ready_exec", {31'd0, a_rdy_exec}, 32'd0);
        chk("write_rsp_valid_t2", {31'd0, a_vld_resp}, 32'd1);
        chk("write_rdata", a_rdata, 32'h0000_00F0);
        chk("write_error", {31'd0, a_err}, 32'd0);
        chk("idle_wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("idle_wr_data", csr_wr_data, 32'd0);

        access(2'd2, 32'h0, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("set0_wr_en", {31'd0, a_wr_en}, 32'd0);
        chk("set0_rdata", a_rdata, 32'h0000_00F0);
        access(2'd3, 32'h0, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("clear0_wr_en", {31'd0, a_wr_en}, 32'd0);
        chk("clear0_rdata", a_rdata, 32'h0000_00F0);
        access(2'd2, 32'h0000_000F, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("set_wr_en", {31'd0, a_wr_en}, 32'd1);
        chk("set_wr_data", a_wr_data, 32'h0000_00FF);
        access(2'd3, 32'h0000_0030, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("clear_wr_data", a_wr_data, 32'h0000_00C0);
        csr_rd_data = 32'h0000_0055;
        access(2'd0, 32'hFFFF_FFFF, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("read_wr_en", {31'd0, a_wr_en}, 32'd0);
        chk("read_rdata", a_rdata, 32'h0000_0055);
        chk("idle_rsp_rdata", rsp_rdata, 32'd0);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // shadow integrity errors and counter saturation
        csr_rd_data = 32'h0000_00F0;
        access(2'd1, 32'h0000_DEAD, 1'b1, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("err_wr_en", {31'd0, a_wr_en}, 32'd0);
        chk("err_rsp_error", {31'd0, a_err}, 32'd1);
        chk("err_count_1", {24'd0, a_cnt}, 32'd1);
        chk("idle_rsp_error", {31'd0, rsp_error}, 32'd0);
        for (int i = 0; i < 299; i++) begin
            access(2'd1, 32'h0000_DEAD, 1'b1, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
                   a_vld_resp, a_rdata, a_err, a_cnt);
        end
        chk("err_count_sat", {24'd0, err_count}, 32'd255);
        access(2'd1, 32'h0000_0001, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("clean_after_err", {31'd0, a_err}, 32'd0);
        chk("clean_wr_en", {31'd0, a_wr_en}, 32'd1);

        // response back-pressure with a second request waiting
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'd1; req_wdata = 32'hA5A5_0000;
        @(posedge clk); #1;
        chk("bp_wr_en", {31'd0, csr_wr_en}, 32'd1);
        req_op = 2'd2; req_wdata = 32'h0000_0001;
        @(posedge clk); #1;
        csr_rd_data = 32'h0000_0076;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0000_00F0);
            chk("bp_rsp_error", {31'd0, rsp_error}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_no_wr_en", {31'd0, csr_wr_en}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_wr_en", {31'd0, csr_wr_en}, 32'd1);
        chk("bp_next_wr_data", csr_wr_data, 32'h0000_0077);
        @(posedge clk); #1;
        chk("bp_next_rdata", rsp_rdata, 32'h0000_0076);
        @(posedge clk); #1;

        // reset pulsed during EXEC
        csr_rd_data = 32'h0000_00F0;
        req_valid = 1'b1; req_op = 2'd1; req_wdata = 32'h0000_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rx_exec_wr_en", {31'd0, csr_wr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rx_wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("rx_wr_data", csr_wr_data, 32'd0);
        chk("rx_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rx_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        chk("rx_hold_wr_en", {31'd0, csr_wr_en}, 32'd0);
        chk("rx_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(2'd1, 32'h0000_2222, 1'b0, a_wr_en, a_wr_data, a_vld_exec, a_rdy_exec,
               a_vld_resp, a_rdata, a_err, a_cnt);
        chk("rx_after_wr_en", {31'd0, a_wr_en}, 32'd1);
        chk("rx_after_wr_data", a_wr_data, 32'h0000_2222);
        chk("rx_after_rdata", a_rdata, 32'h0000_00F0);
        chk("rx_after_valid", {31'd0, a_vld_resp}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_access_seq.md
CSR_ACCESS_SEQ -- requirements
Module: csr_access_seq

Interface
REQ-001 SHALL have parameter Width, default 32: data width of the CSR served.
REQ-002 SHALL have parameter WrMask, default all-ones: bits of the CSR that software may modify.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  access request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-007 SHALL have port req_op_i  input  2  0=READ, 1=WRITE, 2=SET, 3=CLEAR.
REQ-008 SHALL have port req_wdata_i  input  Width  operand for WRITE/SET/CLEAR.
REQ-009 SHALL have port rsp_valid_o  output  1  response valid.
REQ-010 SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-011 SHALL have port rsp_rdata_o  output  Width  CSR value before the access.
REQ-012 SHALL have port rsp_error_o  output  1  shadow-integrity error seen during access.
REQ-013 SHALL have port csr_rd_data_i  input  Width  current CSR value from the register primitive.
REQ-014 SHALL have port csr_rd_error_i  input  1  shadow mismatch flag from the register primitive.
REQ-015 SHALL have port csr_wr_data_o  output  Width  new value to the register primitive.
REQ-016 SHALL have port csr_wr_en_o  output  1  single-cycle write strobe to the register primitive.
REQ-017 SHALL have port err_count_o  output  8  saturating count of errored accesses.

Function
REQ-018 SHALL implement FSM IDLE, EXEC, RESP; IDLE after reset.
REQ-019 IDLE: req_ready_o=1; on req_valid_i capture op and wdata, go to EXEC; otherwise stay.
REQ-020 EXEC (exactly one cycle): req_ready_o=0; sample csr_rd_data_i as old value; go to RESP.
REQ-021 EXEC new value: WRITE=wdata, SET=old|wdata, CLEAR=old&~wdata; then final=(old&~WrMask)|(new&WrMask).
REQ-022 csr_wr_en_o SHALL be high only in EXEC: always for WRITE; for SET/CLEAR only if captured wdata!=0; never for READ.
REQ-023 csr_wr_data_o SHALL equal final value in EXEC and 0 otherwise.
REQ-024 If csr_rd_error_i=1 in EXEC: suppress csr_wr_en_o, set response error, increment err_count_o (saturate at 255, no wrap).
REQ-025 RESP: rsp_valid_o=1, rsp_rdata_o=old, rsp_error_o per REQ-024; both held stable until rsp_ready_i=1, then IDLE.
REQ-026 Latency: request accepted cycle T -> write strobe T+1 -> rsp_valid_o T+2 earliest.
REQ-027 No new request SHALL be accepted before the response handshake completes (one outstanding access).
REQ-028 rsp_rdata_o and rsp_error_o SHALL be 0 outside RESP.

Reset
REQ-029 Reset asserted at any time, including mid-EXEC or mid-RESP, SHALL return to IDLE with no write strobe issued.
REQ-030 Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, csr_wr_en_o=0, csr_wr_data_o=0, err_count_o=0.

Structure
REQ-031 Op encoding enum and FSM state enum SHALL live in shared package csr_access_pkg.
REQ-032 The 8-bit saturating counter SHALL be sub-module csr_err_sat_cnt; all else inline.
REQ-033 SHALL carry a known-value assertion on csr_wr_en_o and req_ready_o.

Verification
REQ-034 CSR=0x0000_00F0, WRITE 0x1234_5678 -> wr_en at T+1 with data 0x1234_5678, rsp rdata 0x0000_00F0, error 0.
REQ-035 CSR=0x0000_00F0, SET 0 and CLEAR 0 -> no wr_en; rsp rdata 0x0000_00F0 each; SET 0x0F -> wr data 0x0000_00FF.
REQ-036 WrMask=0x0000_FFFF, CSR=0xAAAA_0000, WRITE 0xFFFF_FFFF -> wr data 0xAAAA_FFFF.
REQ-037 csr_rd_error_i=1 during EXEC of WRITE -> no wr_en, rsp_error_o=1, err_count_o 0->1; 300 such accesses -> err_count_o=255.
REQ-038 rsp_ready_i low 5 cycles with req_valid_i held high -> rsp stable, req_ready_o=0 throughout, next access starts after handshake.
REQ-039 Reset pulsed in EXEC -> wr_en stays 0, all outputs at reset values, next WRITE completes normally.
